// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller: register map,
// STATUS/CTRL bit positions and the bus FSM state encoding.
package uart_pkg;

    // Word addresses on the Wishbone register port
    localparam logic [1:0] ADR_DATA   = 2'd0;
    localparam logic [1:0] ADR_STATUS = 2'd1;
    localparam logic [1:0] ADR_CTRL   = 2'd2;
    localparam logic [1:0] ADR_RSVD   = 2'd3;

    // STATUS bit positions
    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVR     = 2;
    localparam int STAT_IRQ     = 3;
    localparam int STAT_LVL_LSB = 8;
    localparam int STAT_LVL_W   = 7;

    // CTRL bit positions
    localparam int CTRL_RX_EN   = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_THR_LSB = 8;
    localparam int CTRL_THR_W   = 6;
    localparam int CTRL_FLUSH   = 16;

    typedef enum logic [0:0] {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO holding received characters.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   push, push_data   write request and character
//   pop               read request (ignored when empty)
//   flush             discard all contents; wins over push/pop
//   head              oldest character (valid when !empty)
//   level             number of stored characters, 0..DEPTH
//   full, empty       decoded from the registered level only
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign head  = mem_q[rd_ptr_q];

    // A push on a full FIFO is accepted only when a pop frees a slot in the
    // same cycle; full/empty come from registers, so push never reaches full
    // combinationally.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: buffers characters from the receiver in a FIFO
// and exposes DATA/STATUS/CTRL registers on a Wishbone classic port.
// Ports:
//   i_wb_clk, i_wb_rst_n          clock, synchronous active-low reset
//   i_wb_adr/cyc/stb/we/dat       Wishbone request
//   o_wb_rdt, o_wb_ack            Wishbone response (one-cycle latency)
//   i_rx_done, i_rx_data          character strobe and value from receiver
//   o_irq                         registered level interrupt
//
// Bus FSM:
//   state    | meaning
//   BUS_IDLE | waiting for cyc&stb; side effects fire on leaving this state
//   BUS_ACK  | ack asserted for exactly one cycle, read data valid
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int BITS  = 8
) (
    input  logic            i_wb_clk,
    input  logic            i_wb_rst_n,
    input  logic [1:0]      i_wb_adr,
    input  logic            i_wb_cyc,
    input  logic            i_wb_stb,
    input  logic            i_wb_we,
    input  logic [31:0]     i_wb_dat,
    output logic [31:0]     o_wb_rdt,
    output logic            o_wb_ack,
    input  logic            i_rx_done,
    input  logic [BITS-1:0] i_rx_data,
    output logic            o_irq
);
    localparam int LW = $clog2(DEPTH) + 1;

    bus_state_t             state_q, state_d;
    logic [31:0]            rdt_q, rdt_d;
    logic                   rx_en_q, rx_en_d;
    logic                   irq_en_q, irq_en_d;
    logic [CTRL_THR_W-1:0]  thr_q, thr_d;
    logic                   ovr_q, ovr_d;
    logic                   irq_q, irq_d;

    logic                   go, rd_req, wr_req;
    logic                   fifo_push, fifo_pop, fifo_flush;
    logic [BITS-1:0]        fifo_head;
    logic [LW-1:0]          fifo_level;
    logic                   fifo_full, fifo_empty;
    logic                   ovr_set, ovr_clr, thr_hit;
    logic [31:0]            status_word, ctrl_word;
    logic                   unused_dat;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BITS),
        .LW    (LW)
    ) u_fifo (
        .clk       (i_wb_clk),
        .rst_n     (i_wb_rst_n),
        .push      (fifo_push),
        .push_data (i_rx_data),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head      (fifo_head),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // go is the single cycle in which a request is accepted; every register
    // side effect is qualified by it so it happens exactly once per access.
    assign go     = (state_q == BUS_IDLE) && i_wb_cyc && i_wb_stb;
    assign rd_req = go && !i_wb_we;
    assign wr_req = go && i_wb_we;

    assign fifo_push  = rx_en_q && i_rx_done;
    assign fifo_pop   = rd_req && (i_wb_adr == ADR_DATA);
    assign fifo_flush = wr_req && (i_wb_adr == ADR_CTRL) && i_wb_dat[CTRL_FLUSH];

    // A pop request on a full FIFO always succeeds, so it always makes room.
    assign ovr_set = fifo_push && fifo_full && !fifo_pop;
    assign ovr_clr = wr_req && (i_wb_adr == ADR_STATUS) && i_wb_dat[STAT_OVR];
    assign thr_hit = (thr_q != '0) && (8'(fifo_level) >= 8'(thr_q));

    assign unused_dat = ^i_wb_dat;

    always_comb begin
        status_word = '0;
        status_word[STAT_EMPTY] = fifo_empty;
        status_word[STAT_FULL]  = fifo_full;
        status_word[STAT_OVR]   = ovr_q;
        status_word[STAT_IRQ]   = irq_q;
        status_word[STAT_LVL_LSB +: STAT_LVL_W] = STAT_LVL_W'(fifo_level);

        ctrl_word = '0;
        ctrl_word[CTRL_RX_EN]  = rx_en_q;
        ctrl_word[CTRL_IRQ_EN] = irq_en_q;
        ctrl_word[CTRL_THR_LSB +: CTRL_THR_W] = thr_q;
    end

    always_comb begin
        state_d  = BUS_IDLE;
        rdt_d    = '0;
        rx_en_d  = rx_en_q;
        irq_en_d = irq_en_q;
        thr_d    = thr_q;

        if (state_q == BUS_IDLE && go) state_d = BUS_ACK;

        if (rd_req) begin
            case (i_wb_adr)
                ADR_DATA:   if (!fifo_empty) rdt_d[BITS-1:0] = fifo_head;
                ADR_STATUS: rdt_d = status_word;
                ADR_CTRL:   rdt_d = ctrl_word;
                default:    rdt_d = '0;
            endcase
        end

        if (wr_req && i_wb_adr == ADR_CTRL) begin
            rx_en_d  = i_wb_dat[CTRL_RX_EN];
            irq_en_d = i_wb_dat[CTRL_IRQ_EN];
            thr_d    = i_wb_dat[CTRL_THR_LSB +: CTRL_THR_W];
        end

        // set beats W1C clear when both land in the same cycle
        ovr_d = ovr_set ? 1'b1 : (ovr_clr ? 1'b0 : ovr_q);

        irq_d = irq_en_q && (thr_hit || ovr_q);
    end

    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rst_n) begin
            state_q  <= BUS_IDLE;
            rdt_q    <= '0;
            rx_en_q  <= 1'b0;
            irq_en_q <= 1'b0;
            thr_q    <= '0;
            ovr_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdt_q    <= rdt_d;
            rx_en_q  <= rx_en_d;
            irq_en_q <= irq_en_d;
            thr_q    <= thr_d;
            ovr_q    <= ovr_d;
            irq_q    <= irq_d;
        end
    end

    assign o_wb_ack = (state_q == BUS_ACK);
    assign o_wb_rdt = rdt_q;
    assign o_irq    = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;
    import uart_pkg::*;

    localparam int DEPTH = 8;
    localparam int BITS  = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  adr = '0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] dat = '0;
    logic [31:0] rdt_o;
    logic        ack_o;
    logic        rx_done = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        irq_o;

    int checks = 0;
    int errors = 0;

    // scoreboard / model
    logic [7:0] sb[$];
    bit         m_rx_en = 0, m_irq_en = 0, m_ovr = 0;
    int         m_thr = 0;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DEPTH(DEPTH), .BITS(BITS)) dut (
        .i_wb_clk   (clk),
        .i_wb_rst_n (rst_n),
        .i_wb_adr   (adr),
        .i_wb_cyc   (cyc),
        .i_wb_stb   (stb),
        .i_wb_we    (we),
        .i_wb_dat   (dat),
        .o_wb_rdt   (rdt_o),
        .o_wb_ack   (ack_o),
        .i_rx_done  (rx_done),
        .i_rx_data  (rx_data),
        .o_irq      (irq_o)
    );

    function automatic logic [31:0] exp_status();
        logic [31:0] st;
        int lvl;
        bit irq;
        lvl = sb.size();
        irq = m_irq_en && ((m_thr != 0 && lvl >= m_thr) || m_ovr);
        st = '0;
        st[0] = (lvl == 0);
        st[1] = (lvl == DEPTH);
        st[2] = m_ovr;
        st[3] = irq;
        st[14:8] = 7'(lvl);
        return st;
    endfunction

    function automatic void model_push(input logic [7:0] b);
        if (m_rx_en) begin
            if (sb.size() < DEPTH) sb.push_back(b);
            else m_ovr = 1;
        end
    endfunction

    function automatic logic [31:0] model_pop();
        if (sb.size() == 0) return 32'h0;
        return {24'h0, sb.pop_front()};
    endfunction

    // One bus access; optionally strobes rx_done in the accepting cycle.
    // acks counts ack cycles seen, including one cycle after the first.
    task automatic wb_xfer(input logic w, input logic [1:0] a, input logic [31:0] d,
                           input bit with_rx, input logic [7:0] rx_b,
                           output logic [31:0] rdt, output int acks);
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = w; adr = a; dat = d;
        if (with_rx) begin rx_done = 1; rx_data = rx_b; end
        acks = 0; rdt = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            rx_done = 0;
            if (ack_o) begin
                acks++; rdt = rdt_o; cyc = 0; stb = 0;
                break;
            end
        end
        cyc = 0; stb = 0;
        @(posedge clk); #1;
        if (ack_o) acks++;
        we = 0;
    endtask

    task automatic rx_push(input logic [7:0] b);
        @(posedge clk); #1;
        rx_done = 1; rx_data = b;
        @(posedge clk); #1;
        rx_done = 0;
        model_push(b);
    endtask

    task automatic ctrl_write(input logic [31:0] d);
        logic [31:0] r; int acks;
        wb_xfer(1, ADR_CTRL, d, 0, 8'h0, r, acks);
        m_rx_en = d[0]; m_irq_en = d[1]; m_thr = int'(d[13:8]);
        if (d[16]) sb.delete();
        checks++;
        if (acks !== 1) begin errors++; $display("FAIL ctrl_write_ack: got %0d acks, expected 1", acks); end
    endtask

    task automatic check_status(input string name);
        logic [31:0] r, e; int acks;
        wb_xfer(0, ADR_STATUS, 0, 0, 8'h0, r, acks);
        e = exp_status();
        checks++;
        if (r !== e || acks !== 1) begin
            errors++; $display("FAIL %s: status got %h (acks %0d), expected %h (acks 1)", name, r, acks, e);
        end
    endtask

    task automatic read_data(input string name);
        logic [31:0] r, e; int acks;
        wb_xfer(0, ADR_DATA, 0, 0, 8'h0, r, acks);
        e = model_pop();
        checks++;
        if (r !== e || acks !== 1) begin
            errors++; $display("FAIL %s: data got %h (acks %0d), expected %h (acks 1)", name, r, acks, e);
        end
    endtask

    task automatic test_reset();
        logic [31:0] r; int acks;
        rst_n = 0; cyc = 1; stb = 1; adr = ADR_STATUS;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ack_o !== 0 || rdt_o !== 0 || irq_o !== 0) begin
            errors++; $display("FAIL reset_outputs: ack %b rdt %h irq %b, expected 0 0 0", ack_o, rdt_o, irq_o);
        end
        cyc = 0; stb = 0;
        rst_n = 1;
        check_status("reset_status");
        wb_xfer(0, ADR_CTRL, 0, 0, 8'h0, r, acks);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h, expected 0", r); end
    endtask

    task automatic test_basic();
        logic [31:0] r; int acks;
        ctrl_write(32'h1);
        rx_push(8'h41);
        rx_push(8'h42);
        check_status("basic_level2");
        wb_xfer(1, ADR_DATA, 32'hFF, 0, 8'h0, r, acks);
        wb_xfer(1, ADR_RSVD, 32'hFFFF_FFFF, 0, 8'h0, r, acks);
        checks++;
        if (acks !== 1) begin errors++; $display("FAIL rsvd_write_ack: got %0d, expected 1", acks); end
        wb_xfer(0, ADR_RSVD, 0, 0, 8'h0, r, acks);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL rsvd_read: got %h, expected 0", r); end
        check_status("ignored_writes");
        read_data("basic_pop0");
        read_data("basic_pop1");
        check_status("basic_empty");
    endtask

    task automatic test_overrun();
        logic [31:0] r; int acks;
        for (int i = 0; i < 9; i++) rx_push(8'h60 + 8'(i));
        check_status("overrun_set");
        wb_xfer(1, ADR_STATUS, 32'h4, 0, 8'h0, r, acks);
        m_ovr = 0;
        check_status("overrun_w1c");
    endtask

    task automatic test_full_push_pop();
        logic [31:0] r, e; int acks;
        wb_xfer(0, ADR_DATA, 0, 1, 8'h99, r, acks);
        e = model_pop();
        model_push(8'h99);
        checks++;
        if (r !== e) begin errors++; $display("FAIL full_pushpop_data: got %h, expected %h", r, e); end
        check_status("full_pushpop_status");
        for (int i = 0; i < DEPTH; i++) read_data("drain_full");
        check_status("drain_empty");
    endtask

    task automatic test_empty_push_pop();
        logic [31:0] r, e; int acks;
        wb_xfer(0, ADR_DATA, 0, 1, 8'h55, r, acks);
        e = model_pop();
        model_push(8'h55);
        checks++;
        if (r !== e) begin errors++; $display("FAIL empty_pushpop_data: got %h, expected %h", r, e); end
        check_status("empty_pushpop_status");
        read_data("empty_pushpop_pop");
    endtask

    task automatic test_irq();
        ctrl_write(32'h0303);
        rx_push(8'hA1);
        rx_push(8'hA2);
        checks++;
        if (irq_o !== 0) begin errors++; $display("FAIL irq_below_thr: got %b, expected 0", irq_o); end
        rx_push(8'hA3);
        checks++;
        if (irq_o !== 0) begin errors++; $display("FAIL irq_same_cycle: got %b, expected 0", irq_o); end
        @(posedge clk); #1;
        checks++;
        if (irq_o !== 1) begin errors++; $display("FAIL irq_rise: got %b, expected 1", irq_o); end
        check_status("irq_status");
        read_data("irq_pop");
        checks++;
        if (irq_o !== 0) begin errors++; $display("FAIL irq_fall: got %b, expected 0", irq_o); end
        read_data("irq_drain0");
        read_data("irq_drain1");
    endtask

    task automatic test_flush();
        logic [31:0] r; int acks;
        rx_push(8'h11);
        rx_push(8'h22);
        check_status("pre_flush");
        wb_xfer(1, ADR_CTRL, 32'h0001_0001, 1, 8'hAA, r, acks);
        m_rx_en = 1; m_irq_en = 0; m_thr = 0;
        sb.delete();
        check_status("flush_wins");
    endtask

    task automatic test_rx_disabled();
        logic [31:0] r; int acks;
        ctrl_write(32'h0);
        rx_push(8'h77);
        check_status("rx_disabled_level");
        wb_xfer(0, ADR_DATA, 0, 0, 8'h0, r, acks);
        checks++;
        if (r !== 32'h0 || acks !== 1) begin
            errors++; $display("FAIL empty_read: got %h acks %0d, expected 0 acks 1", r, acks);
        end
    endtask

    task automatic test_reset_mid();
        ctrl_write(32'h0103);
        for (int i = 0; i < 4; i++) rx_push(8'hC0 + 8'(i));
        check_status("pre_reset_level4");
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 0; adr = ADR_STATUS;
        @(posedge clk); #1;
        checks++;
        if (ack_o !== 1 || irq_o !== 1) begin
            errors++; $display("FAIL pre_reset_ack_irq: ack %b irq %b, expected 1 1", ack_o, irq_o);
        end
        rst_n = 0; cyc = 0; stb = 0;
        @(posedge clk); #1;
        checks++;
        if (ack_o !== 0 || rdt_o !== 0 || irq_o !== 0) begin
            errors++; $display("FAIL mid_reset_outputs: ack %b rdt %h irq %b, expected 0 0 0", ack_o, rdt_o, irq_o);
        end
        rst_n = 1;
        sb.delete(); m_ovr = 0; m_rx_en = 0; m_irq_en = 0; m_thr = 0;
        check_status("post_reset_status");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_full_push_pop();
        test_empty_push_pop();
        test_irq();
        test_flush();
        test_rx_disabled();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
